// File: rtl/parking_manager_n.sv
// parking_manager_n: bay occupancy tracker with lowest-free assignment, timed door,
// prescaled per-bay duration counters and one-deep sensor event queuing.
module parking_manager_n #(
  parameter int NUM_SPOTS   = 4,
  parameter int POS_W       = $clog2(NUM_SPOTS),
  parameter int CNT_W       = $clog2(NUM_SPOTS+1),
  parameter int TIME_W      = 16,
  parameter int TICK_CYCLES = 1000,
  parameter int DOOR_CYCLES = 100
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          entry_sensor,
  input  logic                          exit_sensor,
  input  logic [POS_W-1:0]              exiting_position,
  output logic                          door_open,
  output logic                          full,
  output logic                          best_valid,
  output logic [POS_W-1:0]              best_position,
  output logic [NUM_SPOTS-1:0]          parking_spots,
  output logic [CNT_W-1:0]              capacity,
  output logic [NUM_SPOTS*TIME_W-1:0]   parking_time,
  output logic                          reject
);
  localparam int PS_W = $clog2(TICK_CYCLES);
  localparam int DC_W = $clog2(DOOR_CYCLES);
  typedef enum logic {IDLE, OPEN} state_t;
  state_t state, state_n;
  logic entry_q, exit_q, pend_entry, pend_exit;
  logic [POS_W-1:0] pend_exit_pos;
  logic [PS_W-1:0] presc;
  logic [DC_W-1:0] door_cnt, door_cnt_n;
  logic [NUM_SPOTS-1:0] spots_n;
  logic [CNT_W-1:0] used;
  logic tick, do_entry, do_exit, rej_n, exit_ok, clr_entry, clr_exit;
  // Descending scan so the lowest free bay is the last one written
  always_comb begin
    used = '0;
    best_position = '0;
    exit_ok = 1'b0;
    for (int i = NUM_SPOTS-1; i >= 0; i--) begin
      used = used + CNT_W'(parking_spots[i]);
      if (!parking_spots[i]) best_position = POS_W'(i);
      if (parking_spots[i] && pend_exit_pos == POS_W'(i)) exit_ok = 1'b1;
    end
  end
  assign capacity   = CNT_W'(NUM_SPOTS) - used;
  assign full       = (capacity == '0);
  assign best_valid = ~full;
  assign door_open  = (state == OPEN);
  assign tick       = (presc == PS_W'(TICK_CYCLES-1));
  assign clr_exit   = (state == IDLE) && pend_exit;
  assign clr_entry  = (state == IDLE) && !pend_exit && pend_entry;
  always_comb begin
    state_n = state;
    door_cnt_n = door_cnt;
    do_entry = 1'b0;
    do_exit = 1'b0;
    rej_n = 1'b0;
    if (state == OPEN) begin
      state_n = (door_cnt == '0) ? IDLE : OPEN;
      door_cnt_n = (door_cnt == '0) ? door_cnt : door_cnt - 1'b1;
    end else if (pend_exit) begin
      do_exit = exit_ok;
      rej_n = ~exit_ok;
    end else if (pend_entry) begin
      do_entry = ~full;
      rej_n = full;
    end
    if (do_entry || do_exit) begin
      state_n = OPEN;
      door_cnt_n = DC_W'(DOOR_CYCLES-1);
    end
    for (int i = 0; i < NUM_SPOTS; i++)
      spots_n[i] = (parking_spots[i] | (do_entry && best_position == POS_W'(i)))
                   & ~(do_exit && pend_exit_pos == POS_W'(i));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      door_cnt <= '0;
      presc <= '0;
      reject <= 1'b0;
      entry_q <= 1'b0;
      exit_q <= 1'b0;
      pend_entry <= 1'b0;
      pend_exit <= 1'b0;
      pend_exit_pos <= '0;
      parking_spots <= '0;
      parking_time <= '0;
    end else begin
      state <= state_n;
      door_cnt <= door_cnt_n;
      presc <= tick ? '0 : presc + 1'b1;
      reject <= rej_n;
      entry_q <= entry_sensor;
      exit_q <= exit_sensor;
      parking_spots <= spots_n;
      // A new edge is accepted only while its flag is clear
      if (clr_exit) pend_exit <= 1'b0;
      else if (exit_sensor && !exit_q && !pend_exit) begin
        pend_exit <= 1'b1;
        pend_exit_pos <= exiting_position;
      end
      if (clr_entry) pend_entry <= 1'b0;
      else if (entry_sensor && !entry_q) pend_entry <= 1'b1;
      for (int i = 0; i < NUM_SPOTS; i++) begin
        if (do_entry && best_position == POS_W'(i))
          parking_time[i*TIME_W +: TIME_W] <= '0;
        else if (tick && parking_spots[i] && parking_time[i*TIME_W +: TIME_W] != '1)
          parking_time[i*TIME_W +: TIME_W] <= parking_time[i*TIME_W +: TIME_W] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_parking_manager_n.sv
// tb_parking_manager_n: directed scenarios plus random sensor traffic, checked every
// cycle against a bay-list reference model.
module tb_parking_manager_n;
  localparam int N = 5, PW = 3, CW = 3, TW = 4, TICK = 7, DOOR = 5;
  logic clk = 0, reset = 0, entry_sensor = 0, exit_sensor = 0;
  logic [PW-1:0] exiting_position = 0;
  logic door_open, full, best_valid, reject;
  logic [PW-1:0] best_position;
  logic [N-1:0] parking_spots;
  logic [CW-1:0] capacity;
  logic [N*TW-1:0] parking_time;
  int checks = 0, errors = 0, door_cyc = 0, rej_cnt = 0, d0, r0;

  parking_manager_n #(.NUM_SPOTS(N), .TIME_W(TW), .TICK_CYCLES(TICK), .DOOR_CYCLES(DOOR)) dut (
    .clk(clk), .reset(reset), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .exiting_position(exiting_position), .door_open(door_open), .full(full),
    .best_valid(best_valid), .best_position(best_position), .parking_spots(parking_spots),
    .capacity(capacity), .parking_time(parking_time), .reject(reject));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bay list, per-bay minutes, remaining door time, request flags
  int occ[N], tm[N], ppos = 0, door_left = 0, presc = 0;
  bit pe = 0, pn = 0, prev_e = 0, prev_x = 0, rej_m = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin occ[i] = 0; tm[i] = 0; end
      pe = 0; pn = 0; prev_e = 0; prev_x = 0; rej_m = 0; door_left = 0; presc = 0; ppos = 0;
    end else begin
      int was[N];
      int b;
      bit tk, sv_e, sv_x;
      b = -1; sv_e = 0; sv_x = 0; rej_m = 0;
      tk = (presc == TICK-1);
      presc = tk ? 0 : presc + 1;
      for (int i = 0; i < N; i++) was[i] = occ[i];
      if (door_left > 0) door_left--;
      else if (pe) begin
        sv_x = 1;
        if (ppos < N && occ[ppos] != 0) begin occ[ppos] = 0; door_left = DOOR; end
        else rej_m = 1;
      end else if (pn) begin
        sv_e = 1;
        for (int i = N-1; i >= 0; i--) if (occ[i] == 0) b = i;
        if (b < 0) rej_m = 1;
        else begin occ[b] = 1; door_left = DOOR; end
      end
      for (int i = 0; i < N; i++)
        if (i == b) tm[i] = 0;
        else if (tk && was[i] != 0 && tm[i] < (1 << TW) - 1) tm[i]++;
      if (pe) begin if (sv_x) pe = 0; end
      else if (exit_sensor && !prev_x) begin pe = 1; ppos = int'(exiting_position); end
      if (pn) begin if (sv_e) pn = 0; end
      else if (entry_sensor && !prev_e) pn = 1;
      prev_e = entry_sensor;
      prev_x = exit_sensor;
    end
  end

  always @(negedge clk) if (reset) begin
    int free, best, map;
    free = 0; best = 0; map = 0;
    for (int i = N-1; i >= 0; i--) begin
      if (occ[i] == 0) begin free++; best = i; end
      else map |= 1 << i;
    end
    chk("spots", int'(parking_spots), map);
    chk("capacity", int'(capacity), free);
    chk("full", int'(full), int'(free == 0));
    chk("best_valid", int'(best_valid), int'(free != 0));
    chk("best_position", int'(best_position), free == 0 ? 0 : best);
    chk("door_open", int'(door_open), int'(door_left > 0));
    chk("reject", int'(reject), int'(rej_m));
    for (int i = 0; i < N; i++) chk("parking_time", int'(parking_time[i*TW +: TW]), tm[i]);
    if (door_open) door_cyc++;
    if (reject) rej_cnt++;
  end

  task automatic entry_ev();
    entry_sensor = 1; @(negedge clk); entry_sensor = 0;
    repeat (DOOR + 5) @(negedge clk);
  endtask
  task automatic exit_ev(input int pos);
    exiting_position = PW'(pos); exit_sensor = 1; @(negedge clk); exit_sensor = 0;
    repeat (DOOR + 5) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rst_spots", int'(parking_spots), 0);
    chk("rst_capacity", int'(capacity), 5);
    chk("rst_door", int'(door_open), 0);
    d0 = door_cyc;
    repeat (N) entry_ev();
    chk("fill_spots", int'(parking_spots), 5'b11111);
    chk("fill_full", int'(full), 1);
    chk("fill_door_cycles", door_cyc - d0, N * DOOR);
    d0 = door_cyc; r0 = rej_cnt;
    entry_ev();
    chk("full_reject", rej_cnt - r0, 1);
    chk("full_door", door_cyc - d0, 0);
    chk("full_spots", int'(parking_spots), 5'b11111);
    exit_ev(2);
    chk("exit2_best", int'(best_position), 2);
    chk("exit2_capacity", int'(capacity), 1);
    entry_ev();
    chk("reenter_spots", int'(parking_spots), 5'b11111);
    reset = 0; @(negedge clk); reset = 1; @(negedge clk);
    entry_ev(); entry_ev();
    d0 = door_cyc;
    exiting_position = 0; entry_sensor = 1; exit_sensor = 1;
    @(negedge clk);
    entry_sensor = 0; exit_sensor = 0;
    repeat (2 * DOOR + 6) @(negedge clk);
    chk("simul_door_cycles", door_cyc - d0, 2 * DOOR);
    chk("simul_spots", int'(parking_spots), 5'b00011);
    r0 = rej_cnt;
    exit_ev(3);
    exit_ev(6);
    chk("bad_exit_reject", rej_cnt - r0, 2);
    chk("bad_exit_spots", int'(parking_spots), 5'b00011);
    repeat (20 * TICK + 2) @(negedge clk);
    chk("saturate_bay0", int'(parking_time[0 +: TW]), 15);
    entry_sensor = 1; @(negedge clk); entry_sensor = 0;
    repeat (3) @(negedge clk);
    chk("open_before_reset", int'(door_open), 1);
    #2 reset = 0;
    #1;
    chk("reset_door", int'(door_open), 0);
    chk("reset_spots", int'(parking_spots), 0);
    chk("reset_capacity", int'(capacity), 5);
    chk("reset_time", int'(parking_time != '0), 0);
    @(negedge clk); reset = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      entry_sensor = ($urandom_range(0, 3) == 0);
      exit_sensor = ($urandom_range(0, 2) == 0);
      exiting_position = PW'($urandom_range(0, 7));
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parking_manager_n.md
Name: parking_manager_n

Overview:
- Parametrised successor to the fixed 4-spot parking controller core.
- Tracks occupancy of NUM_SPOTS bays and assigns the lowest free bay to each arriving car.
- Drives a timed door, measures per-bay parking duration with a prescaled tick, and queues sensor events that arrive while the door is busy.
- Sits between the debounced entry/exit sensors and the display/LED blinker stage.

Parameters:
- NUM_SPOTS, 4, number of parking bays (2..16).
- POS_W, $clog2(NUM_SPOTS), width of bay index.
- CNT_W, $clog2(NUM_SPOTS+1), width of occupancy count.
- TIME_W, 16, width of each per-bay duration counter.
- TICK_CYCLES, 1000, clk cycles per duration tick (>=2).
- DOOR_CYCLES, 100, clk cycles door stays open per event (>=2).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- entry_sensor  input  1  debounced entry level; rising edge = arrival.
- exit_sensor  input  1  debounced exit level; rising edge = departure.
- exiting_position  input  POS_W  bay index of departing car; sampled on exit edge.
- door_open  output  1  door open indication.
- full  output  1  all bays occupied.
- best_valid  output  1  a free bay exists.
- best_position  output  POS_W  lowest-index free bay; 0 when full.
- parking_spots  output  NUM_SPOTS  occupancy bitmap, bit i = bay i taken.
- capacity  output  CNT_W  number of free bays.
- parking_time  output  NUM_SPOTS*TIME_W  flattened duration counters, bay i at [i*TIME_W +: TIME_W].
- reject  output  1  one-cycle pulse on an illegal request.

Behaviour:
Reset (reset=0, asynchronous):
- State IDLE.
- parking_spots=0, capacity=NUM_SPOTS, all parking_time=0.
- door_open=0, reject=0, edge registers=0, pending flags=0.
- Prescaler and door counter=0.

Edge detection and queuing:
- Sensors are registered once; an edge is cur & ~prev.
- A one-deep pending flag per sensor is set by its edge.
- pend_exit_pos is captured with the exit edge.
- A second edge while a flag is still set is dropped.

FSM:
- IDLE:
  - If pending exit: exit has priority; service it and clear the flag.
  - Else if pending entry: service it and clear the flag.
  - Only one request is serviced per cycle.
- Serviced entry:
  - If full: reject pulses next cycle, stay IDLE.
  - Else: bit best_position set, parking_time[best_position] cleared, door counter loaded with DOOR_CYCLES-1, go OPEN.
- Serviced exit:
  - If pend_exit_pos >= NUM_SPOTS or that bay is free: reject, stay IDLE.
  - Else: clear bit, load door counter, go OPEN.
  - parking_time of the departing bay holds its last value until the bay is re-entered.
- OPEN:
  - door_open=1; counter decrements each cycle.
  - At 0: go IDLE, door_open=0.
  - Door is open exactly DOOR_CYCLES cycles, starting the cycle after service.
- Sensor edges during OPEN only set pending flags. They are serviced in IDLE after the door closes, with full/occupancy evaluated at service time.

Derived outputs:
- Combinational from the registered bitmap, zero added latency.
- capacity = NUM_SPOTS - popcount(parking_spots).
- full = (capacity==0); best_valid = ~full.
- best_position = lowest i with bit i clear.

Timers:
- The prescaler counts 0..TICK_CYCLES-1 and wraps, asserting tick on the wrap cycle.
- On tick, each occupied bay's counter increments, saturating at all-ones.
- If an entry is serviced on a tick cycle, clear has priority for that bay.

Reset mid-operation:
- Door closes immediately.
- Pending requests are lost.

Test Plan:
- Reset, then 4 entry edges spaced >DOOR_CYCLES apart (NUM_SPOTS=4):
  - bays filled 0,1,2,3; capacity 4→0; full=1.
  - door_open high exactly 100 cycles per event.
- 5th entry when full:
  - reject pulses 1 cycle; door stays closed; bitmap stays 4'b1111.
- From full, exit bay 2 then entry:
  - best_position=2 after exit; capacity=1.
  - new car lands in bay 2; parking_time[2] restarts at 0.
- Entry and exit edges in the same cycle (bays 0,1 taken, exit pos 0):
  - exit served first.
  - After door closes, entry served into bay 0.
  - Total door-open time = 200 cycles with one idle cycle between.
- Exit at a free bay (pos 3, bitmap 4'b0011):
  - reject pulse; state unchanged.
- Car in bay 0 for 5*TICK_CYCLES:
  - parking_time[0]=5.
  - With TIME_W=4 and 20 ticks, saturates at 15.
- Assert reset during OPEN:
  - door_open=0 immediately; all outputs at reset values.
